// File: rtl/csi2tx_lb_arbiter.sv
// Local-bus arbiter: shares the register bank port between the AHB slave side and the
// config sequencer, round-robin on contention, with a per-access timeout watchdog.
module csi2tx_lb_arbiter #(
  parameter int ADDSIZ  = 32,
  parameter int DATSIZ  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_ahb,
  input  logic              rst_ahb,
  input  logic              lb_cs,
  input  logic              lb_wrout,
  input  logic [3:0]        lb_beout,
  input  logic [ADDSIZ-1:0] lb_aout,
  input  logic [DATSIZ-1:0] lb_dout,
  output logic              lb_rdyh,
  output logic [DATSIZ-1:0] lb_din,
  output logic              ahb_error_flag,
  input  logic              cfg_req,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_be,
  input  logic [ADDSIZ-1:0] cfg_addr,
  input  logic [DATSIZ-1:0] cfg_wdata,
  output logic              cfg_ack,
  output logic [DATSIZ-1:0] cfg_rdata,
  output logic              cfg_err,
  output logic              rb_cs,
  output logic              rb_wr,
  output logic [3:0]        rb_be,
  output logic [ADDSIZ-1:0] rb_addr,
  output logic [DATSIZ-1:0] rb_wdata,
  input  logic [DATSIZ-1:0] rb_rdata,
  input  logic              rb_ack
);
  typedef enum logic [2:0] {IDLE, AHB_ACC, CFG_ACC, AHB_DONE, AHB_ERR1, AHB_ERR2} state_t;

  state_t            state;
  logic              last_cfg, ahb_pend, rdyh_q;
  logic              h_wr;
  logic [3:0]        h_be;
  logic [ADDSIZ-1:0] h_addr;
  logic [DATSIZ-1:0] h_wdata;
  logic [7:0]        cnt;
  logic              lb_take, ahb_req, cfg_rq, grant_ahb, grant_cfg, tmo;

  // A strobe is only a legal data phase if ready was high the cycle before.
  assign lb_take   = lb_cs & rdyh_q;
  assign ahb_req   = lb_take | ahb_pend;
  assign cfg_rq    = cfg_req & ~cfg_ack;
  assign grant_ahb = (state == IDLE) & ahb_req & (~cfg_rq | last_cfg);
  assign grant_cfg = (state == IDLE) & cfg_rq & ~grant_ahb;
  assign tmo       = (cnt == 8'(TIMEOUT - 1));

  assign lb_rdyh = ((state == IDLE) & ~lb_cs & ~ahb_pend) |
                   (state == AHB_DONE) | (state == AHB_ERR2);
  assign ahb_error_flag = (state == AHB_ERR1) | (state == AHB_ERR2);

  always_ff @(posedge clk_ahb) begin
    if (rst_ahb) begin
      state     <= IDLE;
      last_cfg  <= 1'b1;
      ahb_pend  <= 1'b0;
      rdyh_q    <= 1'b1;
      h_wr      <= 1'b0;
      h_be      <= '0;
      h_addr    <= '0;
      h_wdata   <= '0;
      cnt       <= '0;
      rb_cs     <= 1'b0;
      rb_wr     <= 1'b0;
      rb_be     <= '0;
      rb_addr   <= '0;
      rb_wdata  <= '0;
      lb_din    <= '0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      cfg_ack <= 1'b0;
      rdyh_q  <= lb_rdyh;
      if (lb_take && !grant_ahb) begin
        h_wr     <= lb_wrout;
        h_be     <= lb_beout;
        h_addr   <= lb_aout;
        h_wdata  <= lb_dout;
        ahb_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant_ahb) begin
            rb_wr    <= lb_take ? lb_wrout : h_wr;
            rb_be    <= lb_take ? lb_beout : h_be;
            rb_addr  <= lb_take ? lb_aout  : h_addr;
            rb_wdata <= lb_take ? lb_dout  : h_wdata;
            rb_cs    <= 1'b1;
            cnt      <= '0;
            last_cfg <= 1'b0;
            ahb_pend <= 1'b0;
            state    <= AHB_ACC;
          end else if (grant_cfg) begin
            rb_wr    <= cfg_wr;
            rb_be    <= cfg_be;
            rb_addr  <= cfg_addr;
            rb_wdata <= cfg_wdata;
            rb_cs    <= 1'b1;
            cnt      <= '0;
            last_cfg <= 1'b1;
            state    <= CFG_ACC;
          end
        end
        AHB_ACC, CFG_ACC: begin
          cnt <= cnt + 8'd1;
          if (rb_ack) begin
            rb_cs <= 1'b0;
            if (state == AHB_ACC) begin
              if (!rb_wr) lb_din <= rb_rdata;
              state <= AHB_DONE;
            end else begin
              if (!rb_wr) cfg_rdata <= rb_rdata;
              cfg_ack <= 1'b1;
              cfg_err <= 1'b0;
              state   <= IDLE;
            end
          end else if (tmo) begin
            rb_cs <= 1'b0;
            if (state == AHB_ACC) begin
              lb_din <= '0;
              state  <= AHB_ERR1;
            end else begin
              cfg_ack   <= 1'b1;
              cfg_err   <= 1'b1;
              cfg_rdata <= '0;
              state     <= IDLE;
            end
          end
        end
        AHB_DONE: state <= IDLE;
        AHB_ERR1: state <= AHB_ERR2;
        AHB_ERR2: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csi2tx_lb_arbiter.sv
// Bench for csi2tx_lb_arbiter: bank model, transaction-level reference memory and
// queue-based scoreboards for the AHB and sequencer sides.
module tb_csi2tx_lb_arbiter;
  localparam int ADDSIZ = 32, DATSIZ = 32, TIMEOUT = 64;

  logic clk_ahb = 1'b0, rst_ahb;
  logic lb_cs, lb_wrout, lb_rdyh, ahb_error_flag;
  logic [3:0] lb_beout;
  logic [31:0] lb_aout, lb_dout, lb_din;
  logic cfg_req, cfg_wr, cfg_ack, cfg_err;
  logic [3:0] cfg_be;
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
  logic rb_cs, rb_wr, rb_ack;
  logic [3:0] rb_be;
  logic [31:0] rb_addr, rb_wdata, rb_rdata;

  always #5 clk_ahb = ~clk_ahb;

  csi2tx_lb_arbiter #(.ADDSIZ(ADDSIZ), .DATSIZ(DATSIZ), .TIMEOUT(TIMEOUT)) dut (
    .clk_ahb(clk_ahb), .rst_ahb(rst_ahb),
    .lb_cs(lb_cs), .lb_wrout(lb_wrout), .lb_beout(lb_beout), .lb_aout(lb_aout),
    .lb_dout(lb_dout), .lb_rdyh(lb_rdyh), .lb_din(lb_din), .ahb_error_flag(ahb_error_flag),
    .cfg_req(cfg_req), .cfg_wr(cfg_wr), .cfg_be(cfg_be), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .rb_cs(rb_cs), .rb_wr(rb_wr), .rb_be(rb_be), .rb_addr(rb_addr), .rb_wdata(rb_wdata),
    .rb_rdata(rb_rdata), .rb_ack(rb_ack));

  typedef struct { logic err; logic [31:0] din; } ahb_exp_t;
  typedef struct { logic err; logic wr; logic [31:0] rdata; } cfg_exp_t;
  ahb_exp_t ahbq[$];
  cfg_exp_t cfgq[$];

  // AHB owns words 0..15, the sequencer words 16..31; words 15 and 31 never ack.
  logic [31:0] rmem [32];
  logic [31:0] bmem [32];
  logic [31:0] din_exp;
  int tests = 0, fails = 0;
  int lat_max = 0, bk_wait = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expire(string name);
    tests++; fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic dead(logic [31:0] a);
    return (a[6:2] == 5'd15) || (a[6:2] == 5'd31);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic void ahb_expect(logic wr, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    ahb_exp_t e;
    if (dead(a)) begin
      e.err = 1'b1; din_exp = 32'd0;
    end else begin
      e.err = 1'b0;
      if (wr) rmem[a[6:2]] = merge(rmem[a[6:2]], d, be);
      else    din_exp = rmem[a[6:2]];
    end
    e.din = din_exp;
    ahbq.push_back(e);
  endfunction

  function automatic void cfg_expect(logic wr, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    cfg_exp_t c;
    c.wr = wr;
    if (dead(a)) begin
      c.err = 1'b1; c.rdata = 32'd0;
    end else begin
      c.err = 1'b0;
      if (wr) rmem[a[6:2]] = merge(rmem[a[6:2]], d, be);
      c.rdata = rmem[a[6:2]];
    end
    cfgq.push_back(c);
  endfunction

  task automatic tick;
    @(posedge clk_ahb); #1;
  endtask

  task automatic lb_drive(logic wr, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    lb_wrout = wr; lb_beout = be; lb_aout = a; lb_dout = d; lb_cs = 1'b1;
  endtask

  task automatic cfg_drive(logic wr, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    cfg_wr = wr; cfg_be = be; cfg_addr = a; cfg_wdata = d; cfg_req = 1'b1;
  endtask

  task automatic ahb_wait_done(string name);
    int b = 0;
    do begin @(negedge clk_ahb); b++; end while (!lb_rdyh && b < 400);
    if (!lb_rdyh) expire(name);
  endtask

  task automatic ahb_xfer(logic wr, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    int b = 0;
    @(negedge clk_ahb);
    while (!lb_rdyh && b < 400) begin @(negedge clk_ahb); b++; end
    if (!lb_rdyh) expire("ahb_start");
    tick;
    ahb_expect(wr, be, a, d);
    lb_drive(wr, be, a, d);
    tick;
    lb_cs = 1'b0;
    ahb_wait_done("ahb_done");
  endtask

  task automatic cfg_xfer(logic wr, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    int b = 0;
    cfg_expect(wr, be, a, d);
    cfg_drive(wr, be, a, d);
    do begin @(negedge clk_ahb); b++; end while (!cfg_ack && b < 400);
    if (!cfg_ack) expire("cfg_done");
    tick;
    cfg_req = 1'b0;
  endtask

  task automatic ahb_rand(int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      ahb_xfer(1'($urandom_range(0, 1)), 4'($urandom), {25'd0, 5'($urandom_range(0, 15)), 2'b00}, $urandom);
    end
  endtask

  task automatic cfg_rand(int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 4)) tick;
      cfg_xfer(1'($urandom_range(0, 1)), 4'($urandom), {25'd0, 5'(16 + $urandom_range(0, 15)), 2'b00}, $urandom);
    end
  endtask

  // Register bank: acks after a random latency, dead words never respond.
  initial begin
    rb_ack = 1'b0; rb_rdata = 32'd0;
    forever begin
      @(negedge clk_ahb);
      rb_ack = 1'b0;
      if (rb_cs === 1'b1 && !dead(rb_addr)) begin
        if (bk_wait == 0) begin
          rb_ack = 1'b1;
          if (rb_wr) begin
            bmem[rb_addr[6:2]] = merge(bmem[rb_addr[6:2]], rb_wdata, rb_be);
            rb_rdata = $urandom;
          end else rb_rdata = bmem[rb_addr[6:2]];
          bk_wait = $urandom_range(0, lat_max);
        end else bk_wait--;
      end
    end
  end

  initial begin : mon
    ahb_exp_t e;
    cfg_exp_t c;
    forever begin
      @(negedge clk_ahb);
      if (ahbq.size() > 0 && lb_rdyh) begin
        e = ahbq.pop_front();
        chk("ahb_error", ahb_error_flag, e.err);
        chk("ahb_din", lb_din, e.din);
      end
      if (cfg_ack) begin
        if (cfgq.size() == 0) begin
          tests++; fails++;
          $display("FAIL cfg_ack_unexpected: got ack with no request outstanding");
        end else begin
          c = cfgq.pop_front();
          chk("cfg_err", cfg_err, c.err);
          if (!c.wr) chk("cfg_rdata", cfg_rdata, c.rdata);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, n;
    for (int i = 0; i < 32; i++) begin
      rmem[i] = 32'h5A00_0001 + i * 32'h0001_0101;
      bmem[i] = rmem[i];
    end
    din_exp = 32'd0;
    rst_ahb = 1'b1; lb_cs = 1'b0; lb_wrout = 1'b0; lb_beout = '0; lb_aout = '0; lb_dout = '0;
    cfg_req = 1'b0; cfg_wr = 1'b0; cfg_be = '0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(posedge clk_ahb);
    @(negedge clk_ahb);
    chk("rst_rdyh", lb_rdyh, 1);   chk("rst_rb_cs", rb_cs, 0);
    chk("rst_rb_addr", rb_addr, 0); chk("rst_rb_be", rb_be, 0);
    chk("rst_lb_din", lb_din, 0);   chk("rst_err", ahb_error_flag, 0);
    chk("rst_cfg_ack", cfg_ack, 0); chk("rst_cfg_rdata", cfg_rdata, 0);
    tick; rst_ahb = 1'b0;
    tick;

    // AHB read, bank acks at once
    rmem[4] = 32'hCAFE_F00D; bmem[4] = 32'hCAFE_F00D;
    ahb_expect(1'b0, 4'hF, 32'h10, 32'd0);
    lb_drive(1'b0, 4'hF, 32'h10, 32'd0);
    @(negedge clk_ahb); chk("t1_rdyh_N", lb_rdyh, 0);
    tick; lb_cs = 1'b0;
    @(negedge clk_ahb); chk("t1_rbcs_N1", rb_cs, 1); chk("t1_addr", rb_addr, 32'h10);
    @(negedge clk_ahb); chk("t1_rdyh_N2", lb_rdyh, 1); chk("t1_din", lb_din, 32'hCAFE_F00D);
    tick;

    // CFG uncontended
    cfg_expect(1'b0, 4'hF, 32'h50, 32'd0);
    cfg_drive(1'b0, 4'hF, 32'h50, 32'd0);
    @(negedge clk_ahb); chk("cfg_rbcs_N", rb_cs, 0);
    @(negedge clk_ahb); chk("cfg_rbcs_N1", rb_cs, 1); chk("cfg_addr", rb_addr, 32'h50);
    @(negedge clk_ahb); chk("cfg_ack_N2", cfg_ack, 1);
    tick; cfg_req = 1'b0;

    // Simultaneous AHB write and CFG request: AHB wins first tie
    ahb_expect(1'b1, 4'b0011, 32'h24, 32'h1234);
    cfg_expect(1'b1, 4'hF, 32'h44, 32'hDEAD_0001);
    lb_drive(1'b1, 4'b0011, 32'h24, 32'h1234);
    cfg_drive(1'b1, 4'hF, 32'h44, 32'hDEAD_0001);
    @(negedge clk_ahb); chk("t2_rdyh_N", lb_rdyh, 0);
    tick; lb_cs = 1'b0;
    @(negedge clk_ahb);
    chk("t2_rbcs", rb_cs, 1); chk("t2_addr", rb_addr, 32'h24);
    chk("t2_be", rb_be, 4'b0011); chk("t2_wr", rb_wr, 1); chk("t2_wdata", rb_wdata, 32'h1234);
    @(negedge clk_ahb); chk("t2_rdyh_done", lb_rdyh, 1);
    @(negedge clk_ahb); chk("t2_idle_gap", rb_cs, 0);
    @(negedge clk_ahb); chk("t2_cfg_rbcs", rb_cs, 1); chk("t2_cfg_addr", rb_addr, 32'h44);
    @(negedge clk_ahb); chk("t2_cfg_ack", cfg_ack, 1);
    tick; cfg_req = 1'b0;

    // AHB arrives while CFG access is in progress
    bk_wait = 3;
    cfg_expect(1'b0, 4'hF, 32'h48, 32'd0);
    cfg_drive(1'b0, 4'hF, 32'h48, 32'd0);
    tick;
    ahb_expect(1'b0, 4'hF, 32'h08, 32'd0);
    lb_drive(1'b0, 4'hF, 32'h08, 32'd0);
    @(negedge clk_ahb); chk("t3_rdyh_a", lb_rdyh, 0);
    tick; lb_cs = 1'b0;
    @(negedge clk_ahb); chk("t3_rdyh_b", lb_rdyh, 0); chk("t3_pend", dut.ahb_pend, 1);
    b = 0;
    while (!cfg_ack && b < 100) begin @(negedge clk_ahb); b++; end
    chk("t3_cfg_ack", cfg_ack, 1); chk("t3_rdyh_at_ack", lb_rdyh, 0);
    tick; cfg_req = 1'b0;
    @(negedge clk_ahb); chk("t3_ahb_rbcs", rb_cs, 1); chk("t3_ahb_addr", rb_addr, 32'h08);
    ahb_wait_done("t3_done");

    // Strobe while ready was low is ignored
    tick;
    ahb_expect(1'b0, 4'hF, 32'h04, 32'd0);
    lb_drive(1'b0, 4'hF, 32'h04, 32'd0);
    tick;
    lb_drive(1'b1, 4'hF, 32'h0C, 32'hBAD0_BAD0);
    @(negedge clk_ahb); chk("viol_addr", rb_addr, 32'h04);
    tick; lb_cs = 1'b0;
    ahb_wait_done("viol_done");
    ahb_xfer(1'b0, 4'hF, 32'h0C, 32'd0);

    // AHB timeout
    tick;
    ahb_expect(1'b0, 4'hF, 32'h3C, 32'd0);
    lb_drive(1'b0, 4'hF, 32'h3C, 32'd0);
    tick; lb_cs = 1'b0;
    @(negedge clk_ahb);
    b = 0;
    while (!rb_cs && b < 50) begin @(negedge clk_ahb); b++; end
    n = 0;
    while (rb_cs && n < 300) begin n++; @(negedge clk_ahb); end
    chk("tmo_len", n, TIMEOUT);
    chk("err1_flag", ahb_error_flag, 1); chk("err1_rdyh", lb_rdyh, 0);
    @(negedge clk_ahb);
    chk("err2_flag", ahb_error_flag, 1); chk("err2_rdyh", lb_rdyh, 1); chk("err2_din", lb_din, 0);
    @(negedge clk_ahb); chk("post_err_flag", ahb_error_flag, 0);

    // CFG write timeout, then a normal AHB access
    tick;
    cfg_xfer(1'b1, 4'hF, 32'h7C, 32'h1111_2222);
    ahb_xfer(1'b0, 4'hF, 32'h24, 32'd0);

    // Reset mid-access with an AHB request pending
    tick;
    cfg_drive(1'b0, 4'hF, 32'h7C, 32'd0);
    tick;
    lb_drive(1'b0, 4'hF, 32'h10, 32'd0);
    tick; lb_cs = 1'b0;
    repeat (3) tick;
    chk("rst_mid_rbcs_before", rb_cs, 1);
    rst_ahb = 1'b1; cfg_req = 1'b0;
    @(negedge clk_ahb);
    tick; rst_ahb = 1'b0;
    din_exp = 32'd0;
    @(negedge clk_ahb);
    chk("rstm_rbcs", rb_cs, 0);   chk("rstm_rdyh", lb_rdyh, 1);
    chk("rstm_ack", cfg_ack, 0);  chk("rstm_addr", rb_addr, 0);
    chk("rstm_din", lb_din, 0);   chk("rstm_pend", dut.ahb_pend, 0);
    n = 0;
    repeat (10) begin @(negedge clk_ahb); if (rb_cs) n++; end
    chk("rstm_no_regrant", n, 0);

    // Randomized contention
    lat_max = 4;
    tick;
    fork
      ahb_rand(50);
      cfg_rand(50);
    join
    repeat (5) tick;
    chk("ahbq_empty", ahbq.size(), 0);
    chk("cfgq_empty", cfgq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
